// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes, FSM states, ALU function codes and flag indices
package alu_pkg;

  // Request opcodes (10-15 are illegal)
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_NOR = 4'd4;
  localparam logic [3:0] OP_SHL = 4'd5;
  localparam logic [3:0] OP_SHR = 4'd6;
  localparam logic [3:0] OP_ASR = 4'd7;
  localparam logic [3:0] OP_CMP = 4'd8;
  localparam logic [3:0] OP_MUL = 4'd9;

  // Combinational ALU function select
  localparam logic [2:0] FUN_ADD = 3'b000;
  localparam logic [2:0] FUN_SUB = 3'b001;
  localparam logic [2:0] FUN_AND = 3'b010;
  localparam logic [2:0] FUN_OR  = 3'b011;
  localparam logic [2:0] FUN_NOR = 3'b100;
  localparam logic [2:0] FUN_SHL = 3'b101;
  localparam logic [2:0] FUN_SHR = 3'b110;
  localparam logic [2:0] FUN_ASR = 3'b111;

  // Bit positions inside the {N,Z,C,V} flags register
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [3:0] MUL_LAST = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_MUL,
    ST_RESP
  } state_t;

  function automatic logic op_is_illegal(input logic [3:0] op);
    return op > OP_MUL;
  endfunction

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational 16-bit ALU with NZCV outputs
// Ports: A, B operands; fun function select; R result; N, Z, C, V flags.
module alu
  import alu_pkg::*;
(
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic [2:0]  fun,
  output logic [15:0] R,
  output logic        N,
  output logic        Z,
  output logic        C,
  output logic        V
);

  logic [16:0] sum;

  always_comb begin
    R   = 16'h0000;
    C   = 1'b0;
    V   = 1'b0;
    sum = 17'h00000;
    case (fun)
      FUN_ADD: begin
        sum = {1'b0, A} + {1'b0, B};
        R   = sum[15:0];
        C   = sum[16];
        V   = (A[15] == B[15]) && (sum[15] != A[15]);
      end
      FUN_SUB: begin
        // A + ~B + 1: carry-out is the inverted borrow
        sum = {1'b0, A} + {1'b0, ~B} + 17'd1;
        R   = sum[15:0];
        C   = sum[16];
        V   = (A[15] != B[15]) && (sum[15] != A[15]);
      end
      FUN_AND: R = A & B;
      FUN_OR:  R = A | B;
      FUN_NOR: R = ~(A | B);
      FUN_SHL: R = A << B[3:0];
      FUN_SHR: R = A >> B[3:0];
      FUN_ASR: R = $signed(A) >>> B[3:0];
      default: R = 16'h0000;
    endcase
  end

  assign N = R[15];
  assign Z = (R == 16'h0000);

endmodule

// File: rtl/alu_seq_unit.sv
// rtl/alu_seq_unit.sv - sequenced ALU with shift-add multiplier and flags register
// Ports: clk, rst (sync active-high); req_valid/req_ready/req_op/req_a/req_b request
// handshake; rsp_valid/rsp_ready/rsp_r/rsp_wr/rsp_err response handshake; flags {N,Z,C,V}.
module alu_seq_unit
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_r,
  output logic        rsp_wr,
  output logic        rsp_err,
  output logic [3:0]  flags
);

  state_t      state, state_next;
  logic [3:0]  op_q;
  logic [15:0] a_q, b_q;
  logic [3:0]  cnt;
  logic [15:0] acc, mcand, mplier;
  logic [15:0] mul_sum;

  logic [2:0]  fun;
  logic [15:0] alu_r;
  logic        alu_n, alu_z, alu_c, alu_v;

  // CMP shares the subtractor; its op[2:0] would otherwise select ADD
  assign fun = (op_q == OP_CMP) ? FUN_SUB : op_q[2:0];

  alu u_alu (
    .A   (a_q),
    .B   (b_q),
    .fun (fun),
    .R   (alu_r),
    .N   (alu_n),
    .Z   (alu_z),
    .C   (alu_c),
    .V   (alu_v)
  );

  // One shift-add step: add the shifted multiplicand when the current multiplier bit is set
  assign mul_sum = acc + (mplier[0] ? mcand : 16'h0000);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (op_is_illegal(req_op))  state_next = ST_RESP;
          else if (req_op == OP_MUL)  state_next = ST_MUL;
          else                        state_next = ST_EXEC;
        end
      end
      ST_EXEC: state_next = ST_RESP;
      ST_MUL: begin
        if (cnt == MUL_LAST) state_next = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Response fields and flags are written on the edge that enters RESP, so they
  // change together with rsp_valid rising and stay frozen while RESP waits.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q    <= 4'h0;
      a_q     <= 16'h0000;
      b_q     <= 16'h0000;
      cnt     <= 4'h0;
      acc     <= 16'h0000;
      mcand   <= 16'h0000;
      mplier  <= 16'h0000;
      rsp_r   <= 16'h0000;
      rsp_wr  <= 1'b0;
      rsp_err <= 1'b0;
      flags   <= 4'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            op_q   <= req_op;
            a_q    <= req_a;
            b_q    <= req_b;
            cnt    <= 4'h0;
            acc    <= 16'h0000;
            mcand  <= req_a;
            mplier <= req_b;
            if (op_is_illegal(req_op)) begin
              rsp_r   <= 16'h0000;
              rsp_wr  <= 1'b0;
              rsp_err <= 1'b1;
            end
          end
        end
        ST_EXEC: begin
          rsp_r   <= (op_q == OP_CMP) ? 16'h0000 : alu_r;
          rsp_wr  <= (op_q != OP_CMP);
          rsp_err <= 1'b0;
          flags   <= {alu_n, alu_z, alu_c, alu_v};
        end
        ST_MUL: begin
          acc    <= mul_sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 4'd1;
          if (cnt == MUL_LAST) begin
            rsp_r   <= mul_sum;
            rsp_wr  <= 1'b1;
            rsp_err <= 1'b0;
            flags   <= {mul_sum[15], mul_sum == 16'h0000, 2'b00};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_unit.sv
// tb/tb_alu_seq_unit.sv - self-checking bench for alu_seq_unit against an arithmetic reference model
module tb_alu_seq_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [15:0] req_a, req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_r;
  logic        rsp_wr;
  logic        rsp_err;
  logic [3:0]  flags;

  int checks = 0;
  int errors = 0;
  logic [3:0] model_flags = 4'h0;

  always #5 clk = ~clk;

  alu_seq_unit dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_r     (rsp_r),
    .rsp_wr    (rsp_wr),
    .rsp_err   (rsp_err),
    .flags     (flags)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Reference model: plain integer arithmetic on the documented operation rules
  task automatic model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] fin, output logic [15:0] r, output logic wr,
                       output logic err, output logic [3:0] fout, output int lat);
    int sa, sb, s;
    logic c, v;
    sa = int'($signed(a));
    sb = int'($signed(b));
    c = 1'b0;
    v = 1'b0;
    r = 16'h0000;
    wr = 1'b1;
    err = 1'b0;
    lat = 2;
    case (op)
      4'd0: begin
        s = int'(a) + int'(b);
        r = s[15:0];
        c = (s > 65535);
        v = (sa + sb > 32767) || (sa + sb < -32768);
      end
      4'd1, 4'd8: begin
        r = a - b;
        c = (a >= b);
        v = (sa - sb > 32767) || (sa - sb < -32768);
      end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = ~(a | b);
      4'd5: r = a << b[3:0];
      4'd6: r = a >> b[3:0];
      4'd7: begin
        s = sa;
        for (int i = 0; i < int'(b[3:0]); i++) s = (s < 0) ? -((-s + 1) / 2) : s / 2;
        r = s[15:0];
      end
      4'd9: begin
        s = (int'(a) * int'(b)) % 65536;
        r = s[15:0];
        lat = 17;
      end
      default: begin
        wr = 1'b0;
        err = 1'b1;
        lat = 1;
      end
    endcase
    if (err) fout = fin;
    else     fout = {r[15], r == 16'h0000, c, v};
    if (op == 4'd8) begin
      r = 16'h0000;
      wr = 1'b0;
    end
  endtask

  // Issue one request, check latency/response/flags, optionally stall rsp_ready
  // for 'hold' cycles while poking a request that must be ignored.
  task automatic do_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input int hold, input bit poke);
    logic [15:0] er;
    logic ewr, eerr;
    logic [3:0] ef;
    int elat, lat;
    model(op, a, b, model_flags, er, ewr, eerr, ef, elat);
    @(negedge clk);
    check("req_ready_before", req_ready, 1'b1);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    @(negedge clk);
    req_valid = 1'b0; req_op = 4'($urandom); req_a = 16'($urandom); req_b = 16'($urandom);
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      check("flags_before_rsp", flags, model_flags);
      @(negedge clk);
      lat++;
    end
    check("latency", lat, elat);
    check("rsp_r", rsp_r, er);
    check("rsp_wr", rsp_wr, ewr);
    check("rsp_err", rsp_err, eerr);
    check("flags", flags, ef);
    for (int i = 0; i < hold; i++) begin
      if (poke) begin
        req_valid = 1'b1; req_op = 4'd0; req_a = 16'h1234; req_b = 16'h1111;
      end
      @(negedge clk);
      check("hold_valid", rsp_valid, 1'b1);
      check("hold_ready", req_ready, 1'b0);
      check("hold_r", rsp_r, er);
      check("hold_wr", rsp_wr, ewr);
      check("hold_err", rsp_err, eerr);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    check("after_hs_valid", rsp_valid, 1'b0);
    check("after_hs_ready", req_ready, 1'b1);
    if (poke) begin
      @(negedge clk);
      check("poke_not_queued", {req_ready, rsp_valid}, 2'b10);
    end
    model_flags = ef;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_op = 4'h0; req_a = 16'h0; req_b = 16'h0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_r", rsp_r, 16'h0000);
    check("rst_rsp_wr", rsp_wr, 1'b0);
    check("rst_rsp_err", rsp_err, 1'b0);
    check("rst_flags", flags, 4'h0);
    rst = 1'b0;

    do_op(4'd0, 16'h7FFF, 16'h0001, 0, 1'b0);
    check("add_flags_const", flags, 4'b1001);
    do_op(4'd1, 16'h0000, 16'h0001, 0, 1'b0);
    check("sub_flags_const", flags, 4'b1000);
    do_op(4'd7, 16'h8000, 16'h0001, 0, 1'b0);
    check("asr_flags_const", flags, 4'b1000);
    do_op(4'd8, 16'h0005, 16'h0005, 0, 1'b0);
    check("cmp_flags_const", flags, 4'b0110);
    do_op(4'd9, 16'h0003, 16'h0007, 0, 1'b0);
    check("mul_flags_const", flags, 4'b0000);
    do_op(4'd9, 16'h0100, 16'h0100, 0, 1'b0);
    check("mul0_flags_const", flags, 4'b0100);
    do_op(4'd2, 16'hF0F0, 16'h3C3C, 5, 1'b1);
    do_op(4'hC, 16'hAAAA, 16'h5555, 0, 1'b0);
    check("illegal_flags_kept", flags, 4'b0000);
    do_op(4'd5, 16'h0001, 16'h000F, 1, 1'b0);
    do_op(4'd6, 16'h8000, 16'h0010, 0, 1'b0);

    // Reset in the middle of a multiply (counter value 8)
    @(negedge clk);
    req_valid = 1'b1; req_op = 4'd9; req_a = 16'h1234; req_b = 16'hFFFF;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_req_ready", req_ready, 1'b1);
    check("abort_rsp_valid", rsp_valid, 1'b0);
    check("abort_flags", flags, 4'h0);
    model_flags = 4'h0;
    begin
      int seen;
      seen = 0;
      repeat (20) begin
        @(negedge clk);
        if (rsp_valid) seen++;
      end
      check("abort_no_rsp", seen, 0);
    end

    for (int n = 0; n < 40; n++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 15));
      do_op(op, 16'($urandom), 16'($urandom), int'($urandom_range(0, 2)), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_seq_unit.md
ALU_SEQ_UNIT -- requirements
Module: alu_seq_unit

Interface
REQ-001 clk  input  1  single system clock; all state updates on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 req_valid  input  1  operation request present.
REQ-004 req_ready  output  1  unit can accept a request.
REQ-005 req_op  input  4  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 NOR, 5 SHL, 6 SHR, 7 ASR, 8 CMP, 9 MUL, 10-15 illegal.
REQ-006 req_a, req_b  input  16 each  operands A, B.
REQ-007 rsp_valid  output  1  response present.
REQ-008 rsp_ready  input  1  consumer accepts response.
REQ-009 rsp_r  output  16  result word.
REQ-010 rsp_wr  output  1  result is to be written back (0 for CMP and illegal).
REQ-011 rsp_err  output  1  illegal opcode.
REQ-012 flags  output  4  architectural {N,Z,C,V} register.

Function
REQ-013 States SHALL be IDLE, EXEC, MUL, RESP; req_ready=1 only in IDLE.
REQ-014 Accept on req_valid&&req_ready: latch op/A/B; op 0-8 -> EXEC, op 9 -> MUL (counter=0), op 10-15 -> RESP.
REQ-015 EXEC SHALL last one cycle, drive registered A/B and fun=op[2:0] (fun=001 for CMP) into the combinational ALU, capture R and NZCV, go to RESP.
REQ-016 ALU semantics: 16-bit wrap; ADD C=carry-out; SUB C=NOT borrow; V=signed overflow for ADD/SUB; shift amount=B[3:0]; ASR sign-fills; logic/shift ops C=V=0; N=R[15]; Z=(R==0).
REQ-017 CMP SHALL update flags from A-B, rsp_r=0000, rsp_wr=0.
REQ-018 MUL SHALL be shift-add, 16 iterations (one per cycle, counter 0..15), lower 16 bits of product; N,Z from result, C=V=0.
REQ-019 Latency accept-to-rsp_valid: ops 0-8 two cycles, MUL 17 cycles, illegal one cycle.
REQ-020 flags SHALL update in the same cycle rsp_valid rises, for ops 0-9 only; illegal ops leave flags unchanged, rsp_r=0, rsp_wr=0, rsp_err=1.
REQ-021 RESP: rsp_valid=1; rsp_r/rsp_wr/rsp_err held stable until rsp_valid&&rsp_ready, then -> IDLE (next request accepted earliest the following cycle).
REQ-022 rsp_ready asserted outside RESP SHALL have no effect; req_valid outside IDLE SHALL be ignored (not queued).
REQ-023 rsp_err=0 and rsp_wr=1 for ops 0-7 and 9.

Reset
REQ-024 rst SHALL abort any operation in any state: state=IDLE, req_ready=1, rsp_valid=0, rsp_r=0000, rsp_wr=0, rsp_err=0, flags=0000, MUL counter/accumulator=0.
REQ-025 rst has priority over a simultaneous handshake; no response is emitted for an aborted op.

Structure
REQ-026 Package alu_pkg SHALL hold opcode constants, state enumeration, flag bit indices (N=3,Z=2,C=1,V=0).
REQ-027 Existing combinational alu SHALL be instantiated as the one sub-module (ports A,B,fun,R,N,Z,C,V); MUL datapath is local.

Verification
REQ-028 ADD A=7FFF B=0001 -> rsp_valid 2 cycles after accept, rsp_r=8000, flags=1001, rsp_wr=1.
REQ-029 SUB A=0000 B=0001 -> rsp_r=FFFF, flags=1000; then ASR A=8000 B=0001 -> rsp_r=C000, flags=1000.
REQ-030 CMP A=0005 B=0005 -> rsp_r=0000, rsp_wr=0, flags=0110.
REQ-031 MUL 0003*0007 -> rsp_r=0015, flags=0000 at 17 cycles; MUL 0100*0100 -> rsp_r=0000, flags=0100.
REQ-032 rsp_ready low 5 cycles in RESP -> rsp_* stable, req_ready=0, second req_valid ignored; op 0xC -> rsp_err=1 one cycle after accept, flags unchanged.
REQ-033 rst asserted on MUL iteration 8 -> next cycle req_ready=1, rsp_valid=0, flags=0000, no response ever emitted for that MUL.
